// File: rtl/rcn_dma_sched.sv
// rtl/rcn_dma_sched.sv - round-robin scheduler sharing one DMA engine among level-sensitive request lines
// Offers one channel at a time over valid/ready, then tracks it until done or watchdog abort.
module rcn_dma_sched #(
    parameter int          NUM_CH  = 16,
    parameter logic [15:0] TIMEOUT = 16'd4096,
    parameter logic [3:0]  GAP     = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] enable,
    output logic              grant_valid,
    output logic [3:0]        grant_id,
    input  logic              grant_ready,
    input  logic              done,
    output logic              busy,
    output logic              timeout,
    output logic [3:0]        timeout_id
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OFFER  = 2'd1,
        S_ACTIVE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rr_ptr_q, rr_ptr_d;
    logic        grant_valid_q, grant_valid_d;
    logic [3:0]  grant_id_q, grant_id_d;
    logic [15:0] wdog_q, wdog_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  timeout_id_q, timeout_id_d;

    logic [15:0] elig_w;
    logic [4:0]  cand;
    logic        pick_found;
    logic [3:0]  pick_id;
    logic [3:0]  ptr_after_grant;

    assign elig_w = 16'(req & enable);
    assign ptr_after_grant = (grant_id_q == 4'(NUM_CH - 1)) ? 4'd0 : grant_id_q + 4'd1;

    // Scan from rr_ptr upward, wrapping modulo NUM_CH; first eligible channel wins.
    always_comb begin
        cand       = '0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr_q} + 5'(i);
            if (cand >= 5'(NUM_CH)) begin
                cand = cand - 5'(NUM_CH);
            end
            if (!pick_found && elig_w[cand[3:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            wdog_q        <= '0;
            gap_cnt_q     <= '0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            wdog_q        <= wdog_d;
            gap_cnt_q     <= gap_cnt_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            timeout_id_q  <= timeout_id_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        wdog_d        = wdog_q;
        gap_cnt_d     = gap_cnt_q;
        timeout_d     = 1'b0;
        timeout_id_d  = timeout_id_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    state_d       = S_OFFER;
                end
            end
            S_OFFER: begin
                // Offer is latched: req/enable changes cannot withdraw it.
                if (grant_ready) begin
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = ptr_after_grant;
                    wdog_d        = '0;
                    state_d       = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (done) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (wdog_q == TIMEOUT - 16'd1) begin
                    timeout_d    = 1'b1;
                    timeout_id_d = grant_id_q;
                    gap_cnt_d    = '0;
                    state_d      = S_GAP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            S_GAP: begin
                // Quiet window so a just-serviced level request can drop before rearbitration.
                if (gap_cnt_q == GAP - 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        grant_valid = grant_valid_q;
        grant_id    = grant_id_q;
        busy        = busy_q;
        timeout     = timeout_q;
        timeout_id  = timeout_id_q;
    end

endmodule

// File: tb/tb_rcn_dma_sched.sv
// tb/tb_rcn_dma_sched.sv - self-checking bench for rcn_dma_sched with a round-robin reference model
module tb_rcn_dma_sched;

    localparam int NCH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] enable = '0;
    logic        grant_valid;
    logic [3:0]  grant_id;
    logic        grant_ready = 1'b0;
    logic        done = 1'b0;
    logic        busy;
    logic        timeout;
    logic [3:0]  timeout_id;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    rcn_dma_sched #(.NUM_CH(NCH), .TIMEOUT(16'd16), .GAP(4'd4)) dut (
        .clk(clk), .rst(rst), .req(req), .enable(enable),
        .grant_valid(grant_valid), .grant_id(grant_id), .grant_ready(grant_ready),
        .done(done), .busy(busy), .timeout(timeout), .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rr_pick(input logic [15:0] elig, input int ptr);
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (ptr + k) % NCH;
            if (elig[c]) return 4'(c);
        end
        return 4'd0;
    endfunction

    task automatic do_reset();
        req = '0; enable = '0; grant_ready = 1'b0; done = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Drives one full handshake; returns offered id and ticks waited for the offer (-1 if none).
    task automatic run_transfer(input int acc_dly, input int done_dly,
                                output logic [3:0] id, output int waited);
        waited = 0;
        id = '0;
        while (grant_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (grant_valid !== 1'b1) begin
            waited = -1;
            return;
        end
        id = grant_id;
        repeat (acc_dly) tick();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        repeat (done_dly) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv got %b exp 0", grant_valid); end
        checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_to got %b exp 0", timeout); end
        checks++; if (timeout_id !== 4'd0) begin errors++; $display("FAIL reset_toid got %0d exp 0", timeout_id); end
    endtask

    task automatic test_basic();
        do_reset();
        enable = 16'hFFFF;
        req = 16'h0001;
        tick();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_gv got %b exp 1", grant_valid); end
        checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL basic_id got %0d exp 0", grant_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_offer got %b exp 1", busy); end
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        req = '0;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL basic_gv_after_accept got %b exp 0", grant_valid); end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_gap0 got %b exp 1", busy); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (busy !== (k < 4)) begin
                errors++; $display("FAIL basic_gap_busy k=%0d got %b exp %b", k, busy, (k < 4));
            end
        end
    endtask

    task automatic test_wrap_sequence();
        logic [3:0] id;
        logic [3:0] exp_id;
        int w;
        do_reset();
        req = 16'hFFFF;
        enable = 16'hFFFF;
        for (int n = 0; n < 17; n++) begin
            exp_id = rr_pick(req & enable, m_ptr);
            run_transfer(0, 2, id, w);
            checks++; if (w !== 1) begin errors++; $display("FAIL wrap_latency n=%0d got %0d exp 1", n, w); end
            checks++; if (id !== exp_id) begin errors++; $display("FAIL wrap_id n=%0d got %0d exp %0d", n, id, exp_id); end
            m_ptr = (exp_id + 1) % NCH;
        end
    endtask

    task automatic test_ptr_wrap();
        logic [3:0] id;
        int w;
        do_reset();
        enable = 16'hFFFF;
        req = 16'h0010;
        run_transfer(1, 1, id, w);
        checks++; if (id !== 4'd4) begin errors++; $display("FAIL ptrwrap_first got %0d exp 4", id); end
        req = 16'h0011;
        run_transfer(0, 1, id, w);
        checks++; if (id !== 4'd0) begin errors++; $display("FAIL ptrwrap_wrap got %0d exp 0", id); end
        run_transfer(0, 1, id, w);
        checks++; if (id !== 4'd4) begin errors++; $display("FAIL ptrwrap_next got %0d exp 4", id); end
        m_ptr = 5;
    endtask

    task automatic test_offer_hold();
        int bad;
        do_reset();
        enable = 16'hFFFF;
        req = 16'h0008;
        tick();
        checks++; if (grant_id !== 4'd3 || grant_valid !== 1'b1) begin
            errors++; $display("FAIL hold_offer got gv=%b id=%0d exp gv=1 id=3", grant_valid, grant_id);
        end
        req = '0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            done = (c == 5);
            tick();
            if (grant_valid !== 1'b1 || grant_id !== 4'd3) bad++;
        end
        done = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable unstable cycles got %0d exp 0", bad); end
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        checks++; if (grant_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL hold_accept got gv=%b busy=%b exp gv=0 busy=1", grant_valid, busy);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        enable = 16'hFFFF;
        req = 16'h0040;
        tick();
        checks++; if (grant_id !== 4'd6) begin errors++; $display("FAIL to_grant got %0d exp 6", grant_id); end
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        req = '0;
        early = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (timeout !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early pulses got %0d exp 0", early); end
        tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse_at16 got %b exp 1", timeout); end
        checks++; if (timeout_id !== 4'd6) begin errors++; $display("FAIL to_id got %0d exp 6", timeout_id); end
        tick();
        checks++; if (timeout !== 1'b0 || timeout_id !== 4'd6 || busy !== 1'b1) begin
            errors++; $display("FAIL to_after got to=%b id=%0d busy=%b exp to=0 id=6 busy=1", timeout, timeout_id, busy);
        end
        for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
        req = 16'h0200;
        tick();
        checks++; if (grant_id !== 4'd9) begin errors++; $display("FAIL to2_grant got %0d exp 9", grant_id); end
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        req = '0;
        repeat (15) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_done_priority got %b exp 0", timeout); end
        tick();
        checks++; if (timeout !== 1'b0 || timeout_id !== 4'd6) begin
            errors++; $display("FAIL to_done_after got to=%b id=%0d exp to=0 id=6", timeout, timeout_id);
        end
        for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        enable = 16'hFFFF;
        req = 16'h0080;
        tick();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++; if ({grant_valid, grant_id, busy, timeout, timeout_id} !== 11'd0) begin
            errors++; $display("FAIL midrst_outputs got gv=%b id=%0d busy=%b to=%b toid=%0d exp all 0",
                               grant_valid, grant_id, busy, timeout, timeout_id);
        end
        rst = 1'b0;
        m_ptr = 0;
        enable = '0;
        req = 16'hFFFF;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (grant_valid !== 1'b0 || timeout !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL masked_grant cycles got %0d exp 0", seen); end
        enable = 16'hFFFF;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 4'd0) begin
            errors++; $display("FAIL midrst_ptr got gv=%b id=%0d exp gv=1 id=0", grant_valid, grant_id);
        end
    endtask

    task automatic test_random();
        logic [3:0]  id;
        logic [3:0]  exp_id;
        logic [15:0] r;
        logic [15:0] e;
        int w;
        int k;
        do_reset();
        for (int n = 0; n < 25; n++) begin
            r = 16'($urandom);
            e = 16'($urandom);
            if ((r & e) == 16'd0) begin
                k = $urandom_range(0, NCH - 1);
                r[k] = 1'b1;
                e[k] = 1'b1;
            end
            req = r;
            enable = e;
            exp_id = rr_pick(r & e, m_ptr);
            run_transfer($urandom_range(0, 4), $urandom_range(0, 12), id, w);
            checks++; if (w !== 1) begin errors++; $display("FAIL rand_latency n=%0d got %0d exp 1", n, w); end
            checks++; if (id !== exp_id) begin
                errors++; $display("FAIL rand_id n=%0d req=%h en=%h got %0d exp %0d", n, r, e, id, exp_id);
            end
            m_ptr = (exp_id + 1) % NCH;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_sequence();
        test_ptr_wrap();
        test_offer_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
